// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes, data width, FSM state enums and strobe merge helper
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [AXIL_DATA_WIDTH-1:0] apply_wstrb(
    input logic [AXIL_DATA_WIDTH-1:0] old_val,
    input logic [AXIL_DATA_WIDTH-1:0] new_val,
    input logic [AXIL_STRB_WIDTH-1:0] strb
  );
    logic [AXIL_DATA_WIDTH-1:0] merged;
    merged = old_val;
    for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - 32-bit register array with byte-enable write port and combinational read port
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [AXIL_DATA_WIDTH-1:0] wr_data,
  input  logic [AXIL_STRB_WIDTH-1:0] wr_strb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [AXIL_DATA_WIDTH-1:0] rd_data
);

  logic [AXIL_DATA_WIDTH-1:0] regs [NUM_REGS];

  // Byte-enabled update of the addressed register; an index past NUM_REGS matches no entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        regs[i] <= apply_wstrb(regs[i], wr_data, wr_strb);
      end
    end
  end

  // Read mux: unmatched (out-of-range) index yields zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite register slave; define AXIL_SLV_ERR_RESP_EN for SLVERR on out-of-range accesses
module axi_lite_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [AXIL_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [AXIL_STRB_WIDTH-1:0] S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [AXIL_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  // One extra bit so NUM_REGS == 2**IDX_W is representable
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

`ifdef AXIL_SLV_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  function automatic logic [1:0] resp_for(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_L) ? RESP_OKAY : OOR_RESP;
  endfunction

  // Write channel state
  wr_state_e                  wr_state;
  logic                       awready_q;
  logic                       wready_q;
  logic                       bvalid_q;
  logic [1:0]                 bresp_q;
  logic [IDX_W-1:0]           aw_idx_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q;
  logic [AXIL_STRB_WIDTH-1:0] wstrb_q;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       commit;
  logic [IDX_W-1:0]           commit_idx;
  logic [AXIL_DATA_WIDTH-1:0] commit_data;
  logic [AXIL_STRB_WIDTH-1:0] commit_strb;

  // Read channel state
  rd_state_e                  rd_state;
  logic                       arready_q;
  logic                       rvalid_q;
  logic [1:0]                 rresp_q;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]           ar_idx;
  logic                       ar_hs;
  logic [AXIL_DATA_WIDTH-1:0] bank_rdata;

  // Byte offset within a register is not part of the decode
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID && awready_q;
  assign w_hs   = S_AXI_WVALID  && wready_q;
  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // The commit happens on the edge that completes the second of AW/W, taking
  // whichever half arrives this cycle live and the other half from its latch
  always_comb begin
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_idx  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit     = 1'b1;
          commit_idx = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end
      end
      default: begin
      end
    endcase
  end

  // Write FSM: gather AW and W in any order, raise BVALID after commit, hold until BREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (commit) begin
      wr_state  <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= resp_for(commit_idx);
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_state  <= W_HAVE_AW;
            aw_idx_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            wr_state  <= W_HAVE_W;
            wdata_q   <= S_AXI_WDATA;
            wstrb_q   <= S_AXI_WSTRB;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read FSM: capture register value on AR handshake, hold R until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= bank_rdata;
            rresp_q   <= resp_for(ar_idx);
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rd_state  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          rd_state <= R_IDLE;
        end
      endcase
    end
  end

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_reg_bank (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (commit),
    .wr_idx  (commit_idx),
    .wr_data (commit_data),
    .wr_strb (commit_strb),
    .rd_idx  (ar_idx),
    .rd_data (bank_rdata)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, byte-address width of AWADDR/ARADDR (min 4).
REQ-002 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers (1..2^(ADDR_WIDTH-2)).
REQ-003 SHALL have port ACLK  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port ARESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have write-address ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have write-data ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have write-response ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have read-address ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 SHALL have read-data ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.

Function
REQ-010 SHALL decode register index as ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored; index >= NUM_REGS is out-of-range.
REQ-011 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-012 AWREADY SHALL be 1 in W_IDLE and W_HAVE_W only; WREADY SHALL be 1 in W_IDLE and W_HAVE_AW only.
REQ-013 AW and W handshakes SHALL be accepted in either order or in the same cycle; address and data/strobe latched on their handshake.
REQ-014 Same-cycle AW+W in W_IDLE SHALL go directly to W_RESP; AW only -> W_HAVE_AW; W only -> W_HAVE_W; missing partner completes -> W_RESP.
REQ-015 On entry to W_RESP the register SHALL be updated per byte where WSTRB[i]=1 (bits 8i+7:8i); WSTRB=0 leaves it unchanged but still responds.
REQ-016 BVALID SHALL be 1 from the cycle after the write commits and held with stable BRESP until BVALID&&BREADY; FSM then returns to W_IDLE.
REQ-017 Write latency: 1 cycle from the last of AW/W handshake to BVALID.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-019 On AR handshake, RDATA/RRESP SHALL be registered and RVALID asserted the next cycle (latency 1), held stable until RVALID&&RREADY, then return to R_IDLE.
REQ-020 Read and write channels SHALL operate independently and concurrently.
REQ-021 Read handshake in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-022 BRESP/RRESP SHALL be OKAY (2'b00) for in-range accesses.
REQ-023 Out-of-range write SHALL modify no register; out-of-range read SHALL return RDATA=0.
REQ-024 No AXI input SHALL be required to be stable beyond its handshake cycle.

Reset
REQ-025 While ARESET=1: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0; all registers = 0; both FSMs to idle.
REQ-026 AWREADY/WREADY/ARREADY SHALL rise the first cycle after ARESET deasserts.
REQ-027 Reset asserted mid-transaction SHALL abandon it: no partial register update, no pending response after reset.

Configuration
REQ-028 With AXIL_SLV_ERR_RESP_EN defined, out-of-range accesses SHALL respond SLVERR (2'b10) on BRESP/RRESP.
REQ-029 Without AXIL_SLV_ERR_RESP_EN, out-of-range accesses SHALL respond OKAY; REQ-023 holds in both builds.

Structure
REQ-030 Shared package axil_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, AXI-Lite data width 32, and the write/read FSM state enums.
REQ-031 Register storage with byte-enable write and combinational read index SHALL be sub-module axil_reg_bank; handshake FSMs stay in the top.

Verification
REQ-032 AW+W same cycle, addr 0x04, data 0x12345678, WSTRB 1111 -> BVALID next cycle, BRESP 00; read 0x04 -> RDATA 0x12345678, RRESP 00.
REQ-033 W two cycles before AW (addr 0x08, 0xAABBCCDD) -> AWREADY high while waiting, WREADY low; BVALID 1 cycle after AW handshake; reg2=0xAABBCCDD.
REQ-034 reg1=0x12345678, write 0x04 data 0xFFFFFFFF WSTRB 0101 -> reg1 reads 0x12FF56FF.
REQ-035 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and BRESP/RDATA stable all 5 cycles; no new AW/W/AR accepted.
REQ-036 Write/read addr 0x3C with NUM_REGS=4 -> regs unchanged, RDATA 0; resp 10 with AXIL_SLV_ERR_RESP_EN, 00 without.
REQ-037 ARESET pulsed after AW handshake only, before W -> after reset BVALID=0, all regs 0, AWREADY=WREADY=ARREADY=1 next cycle.
